// File: rtl/cond_eval_unit.sv
// Per-lane condition-code evaluator with an NZCV register and a pending-writer counter.
// Optional macro COND_FWD_BYPASS_EN forwards flag_in into evaluation during a flag write.
module cond_eval_unit #(
  parameter int NUM_CH   = 2,
  parameter int MAX_PEND = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flag_we,
  input  logic [3:0]                      flag_in,
  input  logic                            pend_inc,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [32*NUM_CH-1:0]            in_ir,
  input  logic [NUM_CH-1:0]               in_lane_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_CH-1:0]               out_cond,
  output logic [3:0]                      flags_out,
  output logic                            pend_err,
  output logic [$clog2(MAX_PEND+1)-1:0]   dbg_pend_cnt
);

  localparam int            PW      = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PEND);

  logic [3:0]        r_flags;
  logic [PW-1:0]     r_pend_cnt;
  logic              r_pend_err;
  logic              r_out_valid;
  logic [NUM_CH-1:0] r_out_cond;

  logic              w_slot_free;
  logic              w_flag_indep;
  logic              w_fwd_ok;
  logic              w_accept;
  logic [3:0]        w_eval_flags;
  logic [NUM_CH-1:0] w_cond;

  // flags = {N,Z,C,V}
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf && !z;
      4'h9:    cond_pass = !cf || z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z && (n == v);
      4'hD:    cond_pass = z || (n != v);
      4'hE:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

`ifdef COND_FWD_BYPASS_EN
  assign w_eval_flags = flag_we ? flag_in : r_flags;
  assign w_fwd_ok     = (r_pend_cnt == PW'(1)) && flag_we && !pend_inc;
`else
  assign w_eval_flags = r_flags;
  assign w_fwd_ok     = 1'b0;
`endif

  // AL/NV lanes ignore the flags, so they may pass while writers are still pending.
  always_comb begin
    w_flag_indep = 1'b1;
    w_cond       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_lane_en[k]) begin
        if (in_ir[32*k+29 +: 3] != 3'b111) w_flag_indep = 1'b0;
        w_cond[k] = cond_pass(in_ir[32*k+28 +: 4], w_eval_flags);
      end
    end
  end

  // Handshakes: a transfer happens on an edge where valid && ready; ready never waits on valid.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = w_slot_free && ((r_pend_cnt == '0) || w_flag_indep || w_fwd_ok);
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags     <= 4'b0000;
      r_pend_cnt  <= '0;
      r_pend_err  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_cond  <= '0;
    end else begin
      if (flag_we) r_flags <= flag_in;

      case ({pend_inc, flag_we})
        2'b10: begin
          if (r_pend_cnt == MAX_CNT) r_pend_err <= 1'b1;
          else                       r_pend_cnt <= r_pend_cnt + PW'(1);
        end
        2'b01: begin
          if (r_pend_cnt != '0) r_pend_cnt <= r_pend_cnt - PW'(1);
        end
        default: ;
      endcase

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_cond  <= w_cond;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_cond     = r_out_cond;
  assign flags_out    = r_flags;
  assign pend_err     = r_pend_err;
  assign dbg_pend_cnt = r_pend_cnt;

endmodule
